// File: rtl/cia_eclock_bus.sv
// cia_eclock_bus: E-clock synchronous bus sequencer for the CIA peripherals.
// Rebuilds the E phase from the one-cycle e pulse, parks each CPU request
// until the next E-high window, drives the CIA for exactly that window and
// completes with a four-phase req/ack handshake.
module cia_eclock_bus #(
    parameter int unsigned EDIV  = 10,
    parameter int unsigned EHIGH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       req,
    input  logic       rw,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       ack,
    output logic       eclk,
    output logic       synced,
    output logic       cia_sel,
    output logic       cia_rw,
    output logic [3:0] cia_addr,
    output logic [7:0] cia_wdata,
    input  logic [7:0] cia_rdata
);

    localparam logic [3:0] P_LAST = 4'(EDIV - 1);
    localparam logic [3:0] P_HIGH = 4'(EDIV - EHIGH);
    localparam logic [3:0] P_PRE  = 4'(EDIV - EHIGH - 1);
    localparam logic [3:0] C_LAST = 4'(EHIGH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [3:0] p;
    logic [3:0] p_next;
    logic       primed;
    logic [1:0] state;
    logic [1:0] state_n;
    logic [3:0] cnt;
    logic       accept;
    logic       last_beat;

    assign accept    = (state == S_IDLE) && req && synced;
    assign last_beat = (state == S_ACCESS) && (cnt == C_LAST);

    // Next phase: an e pulse forces phase 0, otherwise count and wrap.
    always_comb begin
        p_next = p + 4'd1;
        if (e || (p == P_LAST)) begin
            p_next = 4'd0;
        end
    end

    // Phase register; eclk is registered from the next phase so it lines up with p.
    always_ff @(posedge clk) begin
        if (reset) begin
            p    <= 4'd0;
            eclk <= 1'b0;
        end else begin
            p    <= p_next;
            eclk <= (p_next >= P_HIGH);
        end
    end

    // Lock tracking: the first e after reset only primes, later pulses must land on the last phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= 1'b0;
            synced <= 1'b0;
        end else if (e) begin
            primed <= 1'b1;
            synced <= primed && (p == P_LAST);
        end else if (p == P_LAST) begin
            synced <= 1'b0;
        end
    end

    // Access sequencing: park until the cycle before E goes high, hold for EHIGH beats, then handshake.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept)        state_n = S_WAIT;
            S_WAIT:   if (p == P_PRE)    state_n = S_ACCESS;
            S_ACCESS: if (cnt == C_LAST) state_n = S_DONE;
            S_DONE:   if (!req)          state_n = S_IDLE;
            default:                     state_n = S_IDLE;
        endcase
    end

    // State, window beat counter and the registered state-decoded strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            cia_sel <= 1'b0;
            ack     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= (state == S_ACCESS) ? cnt + 4'd1 : 4'd0;
            cia_sel <= (state_n == S_ACCESS);
            ack     <= (state_n == S_DONE);
        end
    end

    // Request fields are captured once at acceptance and held through the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            cia_rw    <= 1'b1;
            cia_addr  <= 4'd0;
            cia_wdata <= 8'd0;
        end else if (accept) begin
            cia_rw    <= rw;
            cia_addr  <= addr;
            cia_wdata <= din;
        end
    end

    // Read data is taken in the last window beat and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 8'd0;
        end else if (last_beat && cia_rw) begin
            dout <= cia_rdata;
        end
    end

endmodule

// File: tb/tb_cia_eclock_bus.sv
// tb_cia_eclock_bus: directed test of the E-clock bus sequencer.
module tb_cia_eclock_bus;

    logic       clk = 1'b0;
    logic       reset;
    logic       e;
    logic       req;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ack;
    logic       eclk;
    logic       synced;
    logic       cia_sel;
    logic       cia_rw;
    logic [3:0] cia_addr;
    logic [7:0] cia_wdata;
    logic [7:0] cia_rdata;

    int tests_run = 0;
    int failures  = 0;
    int ph        = 0;
    int lat;
    logic seen;

    cia_eclock_bus #(.EDIV(10), .EHIGH(4)) dut (
        .clk(clk), .reset(reset), .e(e), .req(req), .rw(rw), .addr(addr),
        .din(din), .dout(dout), .ack(ack), .eclk(eclk), .synced(synced),
        .cia_sel(cia_sel), .cia_rw(cia_rw), .cia_addr(cia_addr),
        .cia_wdata(cia_wdata), .cia_rdata(cia_rdata)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given e level; the expected phase is tracked alongside.
    task automatic applyStimulus(input logic e_in);
        e = e_in;
        @(posedge clk);
        #1;
        ph = (reset || e_in) ? 0 : ((ph == 9) ? 0 : ph + 1);
        e = 1'b0;
        checkOutput("eclk", {7'd0, eclk}, {7'd0, (ph >= 6)});
    endtask

    // One cycle with a correctly spaced e pulse generated whenever the phase is 9.
    task automatic stepAuto();
        applyStimulus(ph == 9);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_synced"}, {7'd0, synced}, 8'd0);
        checkOutput({tag, "_eclk"}, {7'd0, eclk}, 8'd0);
        checkOutput({tag, "_ack"}, {7'd0, ack}, 8'd0);
        checkOutput({tag, "_sel"}, {7'd0, cia_sel}, 8'd0);
        checkOutput({tag, "_cia_rw"}, {7'd0, cia_rw}, 8'd1);
        checkOutput({tag, "_cia_addr"}, {4'd0, cia_addr}, 8'd0);
        checkOutput({tag, "_cia_wdata"}, cia_wdata, 8'd0);
        checkOutput({tag, "_dout"}, dout, 8'd0);
    endtask

    initial begin
        reset = 1'b1; e = 1'b0; req = 1'b0; rw = 1'b1; addr = 4'd0; din = 8'd0;
        cia_rdata = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        ph = 0;
        checkResetValues("reset");
        reset = 1'b0;

        // Sync: the first pulse only primes, the second correctly spaced one locks.
        repeat (3) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("sync_first", {7'd0, synced}, 8'd0);
        repeat (9) applyStimulus(1'b0);
        checkOutput("sync_before_second", {7'd0, synced}, 8'd0);
        applyStimulus(1'b1);
        checkOutput("sync_second", {7'd0, synced}, 8'd1);

        // Minimum latency read accepted at p=4.
        while (ph != 4) stepAuto();
        req = 1'b1; rw = 1'b1; addr = 4'hD; cia_rdata = 8'h5A;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            stepAuto();
            checkOutput("min_sel", {7'd0, cia_sel}, {7'd0, (i >= 2 && i <= 5)});
            if (i == 2) begin
                checkOutput("min_addr", {4'd0, cia_addr}, 8'h0D);
                checkOutput("min_rw", {7'd0, cia_rw}, 8'd1);
            end
            if (ack && lat == 0) lat = i;
        end
        checkOutput("min_latency", 8'(lat), 8'd6);
        checkOutput("min_dout", dout, 8'h5A);
        req = 1'b0;
        stepAuto();
        checkOutput("min_ack_drop", {7'd0, ack}, 8'd0);

        // Maximum latency write accepted at p=5; dout must keep the old read.
        while (ph != 5) stepAuto();
        req = 1'b1; rw = 1'b0; addr = 4'h3; din = 8'hC3; cia_rdata = 8'hEE;
        for (int i = 1; i <= 17; i++) begin
            stepAuto();
            checkOutput("max_sel", {7'd0, cia_sel}, {7'd0, (i >= 11 && i <= 14)});
            checkOutput("max_ack", {7'd0, ack}, {7'd0, (i >= 15)});
            if (i == 11) begin
                checkOutput("max_wdata", cia_wdata, 8'hC3);
                checkOutput("max_rw", {7'd0, cia_rw}, 8'd0);
                checkOutput("max_addr", {4'd0, cia_addr}, 8'h03);
            end
        end
        checkOutput("max_dout_kept", dout, 8'h5A);

        // Four-phase hold: ack stays while req stays, no second window.
        for (int i = 0; i < 20; i++) begin
            stepAuto();
            checkOutput("hold_ack", {7'd0, ack}, 8'd1);
            checkOutput("hold_sel", {7'd0, cia_sel}, 8'd0);
        end
        req = 1'b0;
        stepAuto();
        checkOutput("hold_ack_drop", {7'd0, ack}, 8'd0);
        req = 1'b1; rw = 1'b1; addr = 4'h1; din = 8'h00; cia_rdata = 8'h96;
        stepAuto();
        checkOutput("reaccept_addr", {4'd0, cia_addr}, 8'h01);
        checkOutput("reaccept_rw", {7'd0, cia_rw}, 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            stepAuto();
            seen = ack;
        end
        checkOutput("reaccept_ack", {7'd0, seen}, 8'd1);
        checkOutput("reaccept_dout", dout, 8'h96);
        req = 1'b0;
        stepAuto();
        checkOutput("reaccept_ack_drop", {7'd0, ack}, 8'd0);

        // Sync loss: an early pulse drops lock and holds off a new request.
        while (ph != 0) stepAuto();
        repeat (6) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("loss_synced", {7'd0, synced}, 8'd0);
        req = 1'b1; rw = 1'b1; addr = 4'h7;
        for (int i = 1; i <= 11; i++) begin
            stepAuto();
            checkOutput("loss_relock", {7'd0, synced}, {7'd0, (i >= 10)});
            checkOutput("loss_pending_addr", {4'd0, cia_addr}, (i >= 11) ? 8'h07 : 8'h01);
            checkOutput("loss_sel", {7'd0, cia_sel}, 8'd0);
        end

        // Reset in the second window beat aborts the access with no ack.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            stepAuto();
            seen = cia_sel;
        end
        checkOutput("abort_window_seen", {7'd0, seen}, 8'd1);
        stepAuto();
        checkOutput("abort_second_beat", {7'd0, cia_sel}, 8'd1);
        reset = 1'b1;
        applyStimulus(1'b0);
        checkResetValues("abort");
        reset = 1'b0;
        req = 1'b0;
        applyStimulus(1'b0);
        checkOutput("abort_no_ack", {7'd0, ack}, 8'd0);
        checkOutput("abort_no_sel", {7'd0, cia_sel}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
